// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_hold_slot.sv
// Single-entry park register for MDU results; results aimed at x0 are
// accepted but never occupy the slot.
module wb_hold_slot
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN = wb_port_arbiter_pkg::XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic             clear_i,
    output logic             take_o,
    output logic             valid_o,
    output logic [REG_W-1:0] rd_o,
    output logic [XLEN-1:0]  data_o
);

    logic             valid_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  data_q;

    assign take_o  = load_i && (rd_i != {REG_W{1'b0}});
    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;

    // Slot contents: load wins only when empty, so load and clear never overlap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rd_q    <= {REG_W{1'b0}};
            data_q  <= {XLEN{1'b0}};
        end else if (take_o) begin
            valid_q <= 1'b1;
            rd_q    <= rd_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority)
// and the MDU hold slot, with bounded starvation via a one-cycle pipeline freeze.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN     = wb_port_arbiter_pkg::XLEN,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             WB_valid,
    input  logic [REG_W-1:0] WB_rd,
    input  logic [XLEN-1:0]  WB_data,
    input  logic             MDU_valid,
    input  logic [REG_W-1:0] MDU_rd,
    input  logic [XLEN-1:0]  MDU_data,
    output logic             MDU_ready,
    output logic             RF_we,
    output logic [REG_W-1:0] RF_waddr,
    output logic [XLEN-1:0]  RF_wdata,
    output logic             STALL_PIPE,
    output logic             PEND_valid,
    output logic [REG_W-1:0] PEND_rd
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [REG_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             stall_q;

    logic             pipe_req_s, win_pipe_s, win_hold_s, clear_s, take_s;
    logic             hold_valid_s;
    logic [REG_W-1:0] hold_rd_s;
    logic [XLEN-1:0]  hold_data_s;

    assign pipe_req_s = WB_valid && (WB_rd != {REG_W{1'b0}});
    assign MDU_ready  = !hold_valid_s;

    wb_hold_slot #(.XLEN(XLEN)) u_slot (
        .clk_i   (CLK),
        .rst_i   (RES),
        .load_i  (MDU_valid && MDU_ready),
        .rd_i    (MDU_rd),
        .data_i  (MDU_data),
        .clear_i (clear_s),
        .take_o  (take_s),
        .valid_o (hold_valid_s),
        .rd_o    (hold_rd_s),
        .data_o  (hold_data_s)
    );

    // Arbitration: pick the port winner and the next state/counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_pipe_s = 1'b0;
        win_hold_s = 1'b0;
        clear_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_pipe_s = pipe_req_s;
                if (take_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (pipe_req_s && (WB_rd == hold_rd_s)) begin
                    // Younger pipeline write to the same rd makes the parked result dead.
                    win_pipe_s = 1'b1;
                    clear_s    = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                end else if (pipe_req_s) begin
                    win_pipe_s = 1'b1;
                    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_d == CNT_W'(MAX_WAIT)) begin
                        state_d = ST_FORCE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    win_hold_s = 1'b1;
                    clear_s    = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                end
            end
            ST_FORCE: begin
                win_hold_s = 1'b1;
                clear_s    = 1'b1;
                state_d    = ST_IDLE;
                cnt_d      = {CNT_W{1'b0}};
            end
            default: begin
                clear_s = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Write-port mux; address/data keep their last value when nobody wins.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (win_pipe_s) begin
            we_d    = 1'b1;
            waddr_d = WB_rd;
            wdata_d = WB_data;
        end else if (win_hold_s) begin
            we_d    = 1'b1;
            waddr_d = hold_rd_s;
            wdata_d = hold_data_s;
        end else begin
            we_d = 1'b0;
        end
    end

    // FSM state, wait counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            we_q    <= 1'b0;
            waddr_q <= {REG_W{1'b0}};
            wdata_q <= {XLEN{1'b0}};
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            stall_q <= (state_d == ST_FORCE);
        end
    end

    assign RF_we      = we_q;
    assign RF_waddr   = waddr_q;
    assign RF_wdata   = wdata_q;
    assign STALL_PIPE = stall_q;
    assign PEND_valid = hold_valid_s;
    assign PEND_rd    = hold_rd_s;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected RF writes are queued when the
// winning request is driven and compared when RF_we shows up.
module tb_wb_port_arbiter;

    localparam int XLEN = 32;

    logic             CLK = 1'b0;
    logic             RES;
    logic             WB_valid;
    logic [4:0]       WB_rd;
    logic [XLEN-1:0]  WB_data;
    logic             MDU_valid;
    logic [4:0]       MDU_rd;
    logic [XLEN-1:0]  MDU_data;
    logic             MDU_ready;
    logic             RF_we;
    logic [4:0]       RF_waddr;
    logic [XLEN-1:0]  RF_wdata;
    logic             STALL_PIPE;
    logic             PEND_valid;
    logic [4:0]       PEND_rd;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    wb_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(4), .CNT_W(8)) dut (
        .CLK        (CLK),
        .RES        (RES),
        .WB_valid   (WB_valid),
        .WB_rd      (WB_rd),
        .WB_data    (WB_data),
        .MDU_valid  (MDU_valid),
        .MDU_rd     (MDU_rd),
        .MDU_data   (MDU_data),
        .MDU_ready  (MDU_ready),
        .RF_we      (RF_we),
        .RF_waddr   (RF_waddr),
        .RF_wdata   (RF_wdata),
        .STALL_PIPE (STALL_PIPE),
        .PEND_valid (PEND_valid),
        .PEND_rd    (PEND_rd)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every RF write must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RF_we === 1'b1) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_write observed=%0d:%h expected=none", RF_waddr, RF_wdata);
            end else begin
                e = exp_q.pop_front();
                assert ({RF_waddr, RF_wdata} === e) else begin
                    failures++;
                    $error("FAIL rf_write observed=%0d:%h expected=%0d:%h",
                           RF_waddr, RF_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        RES = 1'b1; WB_valid = 1'b1; WB_rd = 5'd4; WB_data = 32'h4444_4444;
        MDU_valid = 1'b1; MDU_rd = 5'd9; MDU_data = 32'h9999_9999;
        cyc(); cyc();
        chk("rst_we", {31'd0, RF_we}, 32'd0);
        chk("rst_waddr", {27'd0, RF_waddr}, 32'd0);
        chk("rst_wdata", RF_wdata, 32'd0);
        chk("rst_stall", {31'd0, STALL_PIPE}, 32'd0);
        chk("rst_pend_valid", {31'd0, PEND_valid}, 32'd0);
        chk("rst_pend_rd", {27'd0, PEND_rd}, 32'd0);
        chk("rst_mdu_ready", {31'd0, MDU_ready}, 32'd1);

        RES = 1'b0; WB_valid = 1'b0; MDU_valid = 1'b0;
        cyc(); cyc();
        chk("post_rst_we", {31'd0, RF_we}, 32'd0);

        // Idle drain
        MDU_valid = 1'b1; MDU_rd = 5'd5; MDU_data = 32'h0000_1234;
        cyc();
        MDU_valid = 1'b0;
        chk("drain_pend_valid", {31'd0, PEND_valid}, 32'd1);
        chk("drain_pend_rd", {27'd0, PEND_rd}, 32'd5);
        chk("drain_mdu_ready", {31'd0, MDU_ready}, 32'd0);
        expect_wr(5'd5, 32'h0000_1234);
        cyc();
        chk("drain_we", {31'd0, RF_we}, 32'd1);
        chk("drain_pend_clear", {31'd0, PEND_valid}, 32'd0);
        chk("drain_ready_back", {31'd0, MDU_ready}, 32'd1);

        // Starvation: four pipeline wins, one forced slot write
        MDU_valid = 1'b1; MDU_rd = 5'd7; MDU_data = 32'h0000_7777;
        cyc();
        MDU_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            WB_valid = 1'b1; WB_rd = 5'(i); WB_data = 32'h100 + 32'(i);
            expect_wr(5'(i), 32'h100 + 32'(i));
            cyc();
            if (i < 4) chk("starve_no_stall", {31'd0, STALL_PIPE}, 32'd0);
        end
        chk("starve_stall", {31'd0, STALL_PIPE}, 32'd1);
        chk("starve_pend", {31'd0, PEND_valid}, 32'd1);
        WB_rd = 5'd5; WB_data = 32'h105;
        expect_wr(5'd7, 32'h0000_7777);
        cyc();
        chk("starve_stall_once", {31'd0, STALL_PIPE}, 32'd0);
        chk("starve_forced_addr", {27'd0, RF_waddr}, 32'd7);
        for (int i = 5; i <= 9; i++) begin
            WB_rd = 5'(i); WB_data = 32'h100 + 32'(i);
            expect_wr(5'(i), 32'h100 + 32'(i));
            cyc();
            chk("starve_after_stall", {31'd0, STALL_PIPE}, 32'd0);
        end
        WB_valid = 1'b0;
        cyc();

        // WAW cancel
        MDU_valid = 1'b1; MDU_rd = 5'd3; MDU_data = 32'h0000_3333;
        cyc();
        MDU_valid = 1'b0;
        WB_valid = 1'b1; WB_rd = 5'd3; WB_data = 32'h0000_00AA;
        expect_wr(5'd3, 32'h0000_00AA);
        cyc();
        WB_valid = 1'b0;
        chk("waw_pend_drop", {31'd0, PEND_valid}, 32'd0);
        cyc(); cyc(); cyc();
        chk("waw_idle_we", {31'd0, RF_we}, 32'd0);
        chk("waw_addr_hold", {27'd0, RF_waddr}, 32'd3);
        chk("waw_data_hold", RF_wdata, 32'h0000_00AA);

        // x0 handling
        MDU_valid = 1'b1; MDU_rd = 5'd6; MDU_data = 32'h0000_6666;
        cyc();
        MDU_valid = 1'b0;
        WB_valid = 1'b1; WB_rd = 5'd0; WB_data = 32'hDEAD_DEAD;
        expect_wr(5'd6, 32'h0000_6666);
        cyc();
        WB_valid = 1'b0;
        chk("x0_hold_wins", {31'd0, PEND_valid}, 32'd0);
        MDU_valid = 1'b1; MDU_rd = 5'd0; MDU_data = 32'hBEEF_BEEF;
        cyc();
        MDU_valid = 1'b0;
        chk("x0_mdu_ready", {31'd0, MDU_ready}, 32'd1);
        chk("x0_mdu_pend", {31'd0, PEND_valid}, 32'd0);
        cyc(); cyc();

        // Reset while the slot is waiting (counter at 2)
        MDU_valid = 1'b1; MDU_rd = 5'd10; MDU_data = 32'h0000_A0A0;
        cyc();
        MDU_valid = 1'b0;
        WB_valid = 1'b1; WB_rd = 5'd11; WB_data = 32'h111;
        expect_wr(5'd11, 32'h111);
        cyc();
        WB_rd = 5'd12; WB_data = 32'h112;
        expect_wr(5'd12, 32'h112);
        cyc();
        RES = 1'b1; WB_rd = 5'd13; WB_data = 32'h113;
        cyc();
        chk("midrst_stall", {31'd0, STALL_PIPE}, 32'd0);
        chk("midrst_pend", {31'd0, PEND_valid}, 32'd0);
        chk("midrst_we", {31'd0, RF_we}, 32'd0);
        RES = 1'b0; WB_valid = 1'b0;
        for (int i = 0; i < 8; i++) cyc();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- Pipeline writeback has priority and cannot be backpressured.
- MDU results are parked in a one-entry hold register and drained into idle port cycles.
- A wait counter bounds MDU starvation by freezing the pipeline for one cycle.
- Sits between the writeback stage, the MDU and the register file; also exports the pending destination for decode hazard interlock.

Parameters:
XLEN, 32, data width.
MAX_WAIT, 4, lost-arbitration cycles tolerated before forcing the hold entry out (legal range 1..255).
CNT_W, 8, wait-counter width (must hold MAX_WAIT).

Ports:
CLK  in  1  clock.
RES  in  1  synchronous reset, active-high.
WB_valid  in  1  pipeline writeback request this cycle.
WB_rd  in  5  pipeline destination register.
WB_data  in  XLEN  pipeline writeback value.
MDU_valid  in  1  MDU result available.
MDU_rd  in  5  MDU destination register.
MDU_data  in  XLEN  MDU result.
MDU_ready  out  1  hold register can accept an MDU result.
RF_we  out  1  register-file write enable (registered).
RF_waddr  out  5  register-file write address (registered).
RF_wdata  out  XLEN  register-file write data (registered).
STALL_PIPE  out  1  freeze the pipeline; writeback must re-present the same request next cycle.
PEND_valid  out  1  hold entry occupied.
PEND_rd  out  5  rd of the hold entry, for decode interlock.

Behaviour:
- One clock domain (CLK); RES is synchronous and active-high.
- On RES: hold invalid, counter 0, state IDLE. RF_we, RF_waddr, RF_wdata, STALL_PIPE, PEND_valid, PEND_rd all 0; MDU_ready 1. RES mid-operation drops any hold entry with no write.
- MDU_ready = !hold_valid. There is no same-cycle drain-and-refill.
- Capture: MDU_valid && MDU_ready loads hold_rd/hold_data at the clock edge.
- A request to x0 is not a port user:
  - WB_rd==0 never produces a write.
  - An MDU result with rd==0 is accepted but discarded; hold stays invalid.
- pipe_req = WB_valid && WB_rd!=0.
- States:
  - IDLE (hold empty).
  - WAIT (hold full, counting losses).
  - FORCE (hold full, pipeline frozen).
- IDLE:
  - pipe_req writes the pipeline value.
  - A capture moves to WAIT with counter 0.
- WAIT:
  - If pipe_req: the pipeline writes and the counter increments. When the counter reaches MAX_WAIT, go to FORCE.
  - If no pipe_req: the hold is written, the hold is cleared, and the state returns to IDLE.
- FORCE:
  - STALL_PIPE=1 (Moore output).
  - The hold is written regardless of WB_valid. The pipeline request is ignored and re-presented next cycle.
  - Next state IDLE, counter 0.
- WAW rule: in WAIT, if pipe_req && WB_rd==hold_rd, the pipeline write proceeds (younger supersedes). The hold entry is cancelled with no write; state IDLE, counter 0.
- Write latency: the selected source appears on RF_* one cycle after selection. RF_we is 0 in cycles with no winner; RF_waddr/RF_wdata then hold their last values.
- PEND_valid/PEND_rd reflect the hold register directly (registered).
- Fairness bound: a hold entry waits at most MAX_WAIT+1 cycles after capture.

Decomposition:
- Shared package holds:
  - XLEN.
  - Register-index width 5.
  - State encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_FORCE=2'd2.
- One natural sub-module: wb_hold_slot, the single-entry valid/rd/data register with load/clear and the x0-discard rule.
- The arbiter FSM, counter and output register stay in the top module.

Test Plan:
- Reset: RES=1 for 2 cycles with MDU_valid=1 and WB_valid=1 -> all outputs 0, MDU_ready=1. Release -> no RF_we until a request.
- Idle drain: MDU_valid=1, rd=5, data=0x1234, WB_valid=0 -> capture at edge 1, PEND_rd=5. Next cycle selects hold -> RF_we=1, waddr=5, wdata=0x1234 one cycle later; PEND_valid=0.
- Starvation: MAX_WAIT=4, capture rd=7, then WB_valid=1 with rd=1..9 every cycle -> 4 pipeline writes, then STALL_PIPE=1 for exactly 1 cycle. The following cycle shows RF_waddr=7, and the held pipeline request is written after.
- WAW cancel: hold rd=3 pending, WB_valid=1, WB_rd=3, data=0xAA -> RF writes 0xAA to x3. PEND_valid drops; no later write to x3.
- x0 handling: WB_rd=0 with a hold pending -> the hold wins the port that cycle. MDU result with rd=0 -> MDU_ready stays 1, PEND_valid stays 0.
- Reset mid-WAIT: RES asserted with the counter at 2 -> hold dropped, STALL_PIPE=0, no write of the held value ever appears.
